// File: rtl/io_pkg.sv
// io_pkg
// Shared I/O address map for the switch/button input port and the read-data
// decoder. Also holds the read multiplexer so that every user decodes the
// addresses the same way.
//   IO_ADDR_SW   : debounced slide switches
//   IO_ADDR_BTN  : debounced button levels
//   IO_ADDR_PEND : button-press pending bits (write-1-to-clear)
//   IO_ADDR_MASK : interrupt mask
package io_pkg;

  localparam logic [3:0] IO_ADDR_SW   = 4'h2;
  localparam logic [3:0] IO_ADDR_BTN  = 4'h4;
  localparam logic [3:0] IO_ADDR_PEND = 4'h8;
  localparam logic [3:0] IO_ADDR_MASK = 4'hC;

  // Inputs arrive already zero-extended to 32 bits; unmapped addresses read 0.
  function automatic logic [31:0] io_read_mux(
    input logic [3:0]  addr,
    input logic [31:0] sw,
    input logic [31:0] btn,
    input logic [31:0] pend,
    input logic [31:0] mask
  );
    logic [31:0] rd;
    rd = 32'h0;
    case (addr)
      IO_ADDR_SW:   rd = sw;
      IO_ADDR_BTN:  rd = btn;
      IO_ADDR_PEND: rd = pend;
      IO_ADDR_MASK: rd = mask;
      default:      rd = 32'h0;
    endcase
    return rd;
  endfunction

endpackage

// File: rtl/sw_btn_input_port_debounce.sv
// sw_btn_input_port_debounce
// One-bit input conditioner: 2-flop synchronizer followed by a debounce
// counter. The stable output follows the synchronized input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-low
//   i_raw    : raw asynchronous input
//   o_stable : debounced level
//   o_rise   : high in the cycle whose edge moves o_stable from 0 to 1
module sw_btn_input_port_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_sync2 ^ r_stable;
  // The DEBOUNCE_CYCLES-th differing cycle is the one where the counter
  // already holds DEBOUNCE_CYCLES-1.
  assign w_done = w_diff & (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_done & r_sync2;

endmodule

// File: rtl/sw_btn_input_port.sv
// sw_btn_input_port
// Memory-mapped switch and push-button input port with per-bit debouncing,
// press-pending latches (write-1-to-clear), an interrupt mask and a level irq.
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-low
//   SWITCH     : raw slide switches (asynchronous)
//   BTN        : raw push buttons (asynchronous, 1 = pressed)
//   IOAddr     : low 4 address bits of the I/O access
//   IOWrite    : store strobe
//   writedata  : store data
//   IOReadData : combinational read data for IOAddr
//   irq        : registered |(pending & mask)
module sw_btn_input_port
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_BTN         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         SWITCH,
  input  logic [NUM_BTN-1:0] BTN,
  input  logic [3:0]         IOAddr,
  input  logic               IOWrite,
  input  logic [31:0]        writedata,
  output logic [31:0]        IOReadData,
  output logic               irq
);

  logic [7:0]         w_sw_stable;
  logic [7:0]         w_unused_sw_rise;
  logic [NUM_BTN-1:0] w_btn_stable;
  logic [NUM_BTN-1:0] w_btn_rise;
  logic               w_unused_wdata;
  logic               w_wr_pend;
  logic               w_wr_mask;

  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] r_mask;
  logic               r_irq;

  for (genvar g = 0; g < 8; g++) begin : g_sw
    sw_btn_input_port_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (SWITCH[g]),
      .o_stable(w_sw_stable[g]),
      .o_rise  (w_unused_sw_rise[g])
    );
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    sw_btn_input_port_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (BTN[g]),
      .o_stable(w_btn_stable[g]),
      .o_rise  (w_btn_rise[g])
    );
  end

  // Only the low NUM_BTN data bits are ever stored.
  assign w_unused_wdata = ^writedata[31:NUM_BTN];

  assign w_wr_pend = IOWrite && (IOAddr == IO_ADDR_PEND);
  assign w_wr_mask = IOWrite && (IOAddr == IO_ADDR_MASK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      // A press debouncing on the same edge as a clear must not be lost,
      // so the new press is OR-ed in after the clear.
      if (w_wr_pend) begin
        r_pending <= (r_pending & ~writedata[NUM_BTN-1:0]) | w_btn_rise;
      end else begin
        r_pending <= r_pending | w_btn_rise;
      end
      if (w_wr_mask) begin
        r_mask <= writedata[NUM_BTN-1:0];
      end
      r_irq <= |(r_pending & r_mask);
    end
  end

  assign IOReadData = io_read_mux(IOAddr,
                                  32'(w_sw_stable),
                                  32'(w_btn_stable),
                                  32'(r_pending),
                                  32'(r_mask));
  assign irq = r_irq;

endmodule

// File: tb/tb_sw_btn_input_port.sv
module tb_sw_btn_input_port;

  localparam int D  = 4;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    SWITCH = '0;
  logic [NB-1:0] BTN = '0;
  logic [3:0]    IOAddr = '0;
  logic          IOWrite = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   IOReadData;
  logic          irq;

  always #5 clk = ~clk;

  sw_btn_input_port #(.DEBOUNCE_CYCLES(D), .NUM_BTN(NB)) dut (
    .clk       (clk),
    .reset     (reset),
    .SWITCH    (SWITCH),
    .BTN       (BTN),
    .IOAddr    (IOAddr),
    .IOWrite   (IOWrite),
    .writedata (writedata),
    .IOReadData(IOReadData),
    .irq       (irq)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: raw sample history per edge; a bit's debounced value
  // flips when the D samples the synchronizer delivered (edges n-2..n-D-1)
  // all disagree with it.
  logic [11:0]   hist[$];
  logic [7:0]    m_sw   = '0;
  logic [NB-1:0] m_btn  = '0;
  logic [NB-1:0] m_pend = '0;
  logic [NB-1:0] m_mask = '0;
  logic          m_irq  = 1'b0;

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    case (a)
      4'h2:    return {24'b0, m_sw};
      4'h4:    return {28'b0, m_btn};
      4'h8:    return {28'b0, m_pend};
      4'hC:    return {28'b0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step();
    logic [11:0]   cur;
    logic [11:0]   nxt;
    logic [NB-1:0] rise;
    logic          irq_n;
    bit            all_diff;
    if (!reset) begin
      m_sw = '0; m_btn = '0; m_pend = '0; m_mask = '0; m_irq = 1'b0;
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back(12'h0);
      return;
    end
    hist.push_back({BTN, SWITCH});
    void'(hist.pop_front());
    cur = {m_btn, m_sw};
    nxt = cur;
    for (int b = 0; b < 12; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) if (hist[k][b] == cur[b]) all_diff = 1'b0;
      if (all_diff) nxt[b] = hist[0][b];
    end
    rise  = nxt[11:8] & ~cur[11:8];
    irq_n = |(m_pend & m_mask);
    if (IOWrite && IOAddr == 4'h8) m_pend = m_pend & ~writedata[NB-1:0];
    m_pend = m_pend | rise;
    if (IOWrite && IOAddr == 4'hC) m_mask = writedata[NB-1:0];
    m_sw  = nxt[7:0];
    m_btn = nxt[11:8];
    m_irq = irq_n;
  endfunction

  task automatic cyc(input logic [7:0] sw, input logic [NB-1:0] btn,
                     input logic [3:0] addr, input logic wr,
                     input logic [31:0] wd, input logic rst_n);
    @(negedge clk);
    SWITCH = sw; BTN = btn; IOAddr = addr; IOWrite = wr;
    writedata = wd; reset = rst_n;
    @(posedge clk);
    model_step();
    exp_q.push_back('{rd: exp_read(IOAddr), irq: m_irq});
  endtask

  task automatic idle(input logic [7:0] sw, input logic [NB-1:0] btn,
                      input logic [3:0] addr, input int n);
    for (int i = 0; i < n; i++) cyc(sw, btn, addr, 1'b0, 32'h0, 1'b1);
  endtask

  // Monitor: the DUT presents a response every cycle; compare it to the
  // oldest expectation once outputs have settled after the edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (IOReadData !== e.rd) begin
        bad++;
        $display("FAIL rdata t=%0t addr=%h got=%h exp=%h", $time, IOAddr, IOReadData, e.rd);
      end
      total++;
      if (irq !== e.irq) begin
        bad++;
        $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e.irq);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    sw_r;
    logic [NB-1:0] btn_r;
    logic [3:0]    addr;
    logic          wr;
    logic [31:0]   wd;
    logic          rst_n;
    int            sel;

    for (int i = 0; i < D + 2; i++) hist.push_back(12'h0);

    // Reset with all inputs high, then read every mapped register.
    cyc(8'hFF, 4'hF, 4'h2, 1'b0, 32'h0, 1'b0);
    cyc(8'hFF, 4'hF, 4'h4, 1'b0, 32'h0, 1'b0);
    cyc(8'hFF, 4'hF, 4'h2, 1'b0, 32'h0, 1'b1);
    cyc(8'hFF, 4'hF, 4'h4, 1'b0, 32'h0, 1'b1);
    cyc(8'hFF, 4'hF, 4'h8, 1'b0, 32'h0, 1'b1);
    cyc(8'hFF, 4'hF, 4'hC, 1'b0, 32'h0, 1'b1);
    cyc(8'h00, 4'h0, 4'h2, 1'b0, 32'h0, 1'b0);
    idle(8'h00, 4'h0, 4'h2, 4);

    // Short glitch on SWITCH[0] must not propagate.
    idle(8'h01, 4'h0, 4'h2, 3);
    idle(8'h00, 4'h0, 4'h2, 8);

    // Held switch pattern: 0 through edge 5, 0xA5 from edge 6.
    idle(8'hA5, 4'h0, 4'h2, 9);

    // Masked button 1 press, clear while held, no re-trigger.
    cyc(8'hA5, 4'h0, 4'hC, 1'b1, 32'h2, 1'b1);
    idle(8'hA5, 4'h2, 4'h8, 4);
    idle(8'hA5, 4'h2, 4'h4, 4);
    cyc(8'hA5, 4'h2, 4'h8, 1'b1, 32'h2, 1'b1);
    idle(8'hA5, 4'h2, 4'h8, 10);
    idle(8'hA5, 4'h0, 4'h8, 8);

    // Button 0 debounces on the same edge as a clear of pending[0].
    idle(8'hA5, 4'h1, 4'h8, 5);
    cyc(8'hA5, 4'h1, 4'h8, 1'b1, 32'h1, 1'b1);
    idle(8'hA5, 4'h1, 4'h8, 4);

    // pending=0x3 with all unmasked, then a single reset edge.
    cyc(8'hA5, 4'h1, 4'hC, 1'b1, 32'hF, 1'b1);
    idle(8'hA5, 4'h3, 4'h8, 8);
    cyc(8'hA5, 4'h3, 4'h8, 1'b0, 32'h0, 1'b0);
    idle(8'hA5, 4'h3, 4'h8, 2);
    idle(8'hA5, 4'h3, 4'hC, 2);
    idle(8'h00, 4'h0, 4'h8, 8);

    // Randomized traffic.
    sw_r = 8'h00;
    btn_r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) sw_r[3'($urandom_range(7))] ^= 1'b1;
      if ($urandom_range(5) == 0) btn_r[2'($urandom_range(NB - 1))] ^= 1'b1;
      sel = int'($urandom_range(4));
      case (sel)
        0:       addr = 4'h2;
        1:       addr = 4'h4;
        2:       addr = 4'h8;
        3:       addr = 4'hC;
        default: addr = 4'($urandom_range(15));
      endcase
      wr    = ($urandom_range(5) == 0);
      wd    = $urandom;
      rst_n = ($urandom_range(299) != 0);
      cyc(sw_r, btn_r, addr, wr, wd, rst_n);
    end

    repeat (3) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_btn_input_port.md
SW_BTN_INPUT_PORT -- requirements
Module: sw_btn_input_port

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive clk cycles an input must differ from its debounced value before that value changes (legal range 2..255).
REQ-002 The block SHALL have parameter NUM_BTN, default 4: number of push-button inputs.
REQ-003 The block SHALL have port clk  input  1: system clock; the single clock for all state.
REQ-004 The block SHALL have port reset  input  1: reset, synchronous and active-low.
REQ-005 The block SHALL have port SWITCH  input  8: raw slide switches, asynchronous to clk.
REQ-006 The block SHALL have port BTN  input  NUM_BTN: raw push buttons, asynchronous to clk, 1 = pressed.
REQ-007 The block SHALL have port IOAddr  input  4: low 4 address bits of the current I/O access.
REQ-008 The block SHALL have port IOWrite  input  1: store to an I/O address this cycle.
REQ-009 The block SHALL have port writedata  input  32: store data.
REQ-010 The block SHALL have port IOReadData  output  32: read data for IOAddr.
REQ-011 The block SHALL have port irq  output  1: level interrupt request, 1 = an unmasked button press is pending.

Function
REQ-012 Each SWITCH and BTN bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each synchronized bit SHALL have its own debounce counter: cleared when the synced value equals the stable value; incremented when they differ; on the DEBOUNCE_CYCLES-th consecutive differing cycle, stable takes the synced value and the counter clears.
REQ-014 Latency SHALL be exactly DEBOUNCE_CYCLES+2 clk edges from the first edge sampling a new held raw value to the stable value changing (6 edges at default).
REQ-015 A mismatch lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave the stable value unchanged and clear the counter.
REQ-016 Register map (IOAddr): 4'h2 = {24'b0, sw_stable}; 4'h4 = button level {0, btn_stable}; 4'h8 = pending; 4'hC = mask; any other address SHALL read 32'h0.
REQ-017 IOReadData SHALL be combinational from IOAddr and registered state, with no read side effects.
REQ-018 A pending bit SHALL be set on the same edge its btn_stable bit changes 0->1; releases (1->0) SHALL NOT set it.
REQ-019 IOWrite at 4'h8 SHALL clear each pending bit where writedata has a 1 (write-1-to-clear); if a new press occurs on that same edge, set SHALL win.
REQ-020 IOWrite at 4'hC SHALL load mask from writedata[NUM_BTN-1:0]; IOWrite at 4'h2, 4'h4 or unmapped addresses SHALL have no effect.
REQ-021 irq SHALL equal |(pending & mask), changing one edge after the pending or mask update.
REQ-022 A button held down SHALL set pending once only; pending is not set again until a release and a new press are each debounced.

Reset
REQ-023 On a clk edge with reset=0, synchronizers, counters, stable values, pending and mask SHALL all go to 0; IOReadData reads 0 at every address and irq=0 from the following cycle.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; a press in progress SHALL NOT produce a pending bit after reset.

Structure
REQ-025 Address constants (IO_ADDR_SW=4'h2, IO_ADDR_BTN=4'h4, IO_ADDR_PEND=4'h8, IO_ADDR_MASK=4'hC) SHALL reside in shared package io_pkg, for use by the output decoder too.
REQ-026 A one-bit sub-module debouncer (synchronizer + counter of width $clog2(DEBOUNCE_CYCLES+1), parameter DEBOUNCE_CYCLES) SHALL be instantiated 8+NUM_BTN times.

Verification (DEBOUNCE_CYCLES=4, NUM_BTN=4)
REQ-027 Reset held low 2 edges with inputs 0xFF/0xF -> IOReadData 0 at 4'h2/4/8/C, irq=0.
REQ-028 SWITCH 0x00->0xA5 held, IOAddr=4'h2 -> reads 0x0 through edge 5, 0x000000A5 from edge 6.
REQ-029 SWITCH[0] high 3 cycles then low (glitch) -> 4'h2 stays 0x0 throughout.
REQ-030 mask=0x2, BTN[1] pressed and held -> after 6 edges 4'h4=0x2, 4'h8=0x2, irq=1; write 0x2 to 4'h8 -> pending 0x0, irq=0, stays 0 while still held.
REQ-031 BTN[0] press debounces on the same edge as an IOWrite of 0x1 to 4'h8 -> pending[0] remains 1.
REQ-032 pending=0x3, mask=0xF, irq=1, then reset low one edge -> pending 0x0, mask 0x0, irq=0.
